// File: rtl/gridx_mem_pkg.sv
// Shared types and helpers for the shared-SRAM bank arbiter.
// Widths here describe the default 8-bank configuration; modules derive their own from parameters.
package gridx_mem_pkg;

  localparam int NUM_BANKS_DEF = 8;
  localparam int BANK_BITS     = $clog2(NUM_BANKS_DEF);

  function automatic int warp_of(input int r, input int threads_per_warp);
    return r / threads_per_warp;
  endfunction

  // Saturating add, clamped to max_v.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_v}) ? max_v : s[31:0];
  endfunction

endpackage

// File: rtl/rr_age_picker.sv
// Per-bank winner select: aged requesters first, otherwise any requester, round-robin from rr_ptr_i.
// Purely combinational, one-hot (or zero) grant.
module rr_age_picker
  import gridx_mem_pkg::*;
#(
  parameter int N     = 8,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req_mask_i,
  input  logic [N-1:0]     aged_mask_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [N-1:0]     grant_o
);

  logic [N-1:0]     pool;
  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    pool    = (|aged_mask_i) ? aged_mask_i : req_mask_i;
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(rr_ptr_i) + i) % N);
      if (!found && pool[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_arbiter_mc.sv
// Shared-SRAM bank arbiter: per-bank round-robin with age escalation, read coalescing, busy occupancy.
// req_ready is combinational; bank strobes/address/owners, stalls and statistics are registered (1 cycle).
module bank_arbiter_mc
  import gridx_mem_pkg::*;
#(
  parameter int NUM_REQ          = 8,
  parameter int NUM_BANKS        = 8,
  parameter int NUM_WARPS        = 2,
  parameter int THREADS_PER_WARP = 4,
  parameter int ADDR_W           = 10,
  parameter int BANK_BUSY_CYCLES = 1,
  parameter int AGE_LIMIT        = 7,
  parameter int COALESCE_READS   = 1,
  parameter int CNT_W            = 8,
  localparam int BK_W            = $clog2(NUM_BANKS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*BK_W-1:0]        req_bank,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ-1:0]             req_is_write,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_BANKS-1:0]           bank_rd_en,
  output logic [NUM_BANKS-1:0]           bank_wr_en,
  output logic [NUM_BANKS*ADDR_W-1:0]    bank_addr,
  output logic [NUM_BANKS*NUM_REQ-1:0]   bank_owner_mask,
  output logic [NUM_WARPS-1:0]           warp_stall,
  input  logic                           stat_clear,
  output logic [NUM_WARPS*CNT_W-1:0]     warp_conflict_cnt,
  output logic [NUM_WARPS*CNT_W-1:0]     warp_grant_cnt
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AGE_W  = $clog2(AGE_LIMIT + 1);
  localparam int BUSY_W = (BANK_BUSY_CYCLES > 1) ? $clog2(BANK_BUSY_CYCLES) : 1;
  localparam logic [AGE_W-1:0]  AGE_MAX     = AGE_W'(AGE_LIMIT);
  localparam logic [BUSY_W-1:0] BUSY_RELOAD = BUSY_W'(BANK_BUSY_CYCLES - 1);
  localparam logic [31:0]       CNT_MAX     = 32'((64'd1 << CNT_W) - 64'd1);

  logic [BK_W-1:0]    r_bank [NUM_REQ];
  logic [ADDR_W-1:0]  r_addr [NUM_REQ];

  logic [NUM_REQ-1:0] bank_req  [NUM_BANKS];
  logic [NUM_REQ-1:0] bank_aged [NUM_BANKS];
  logic [NUM_REQ-1:0] bank_gnt  [NUM_BANKS];
  logic [NUM_REQ-1:0] bank_acc  [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_hit, win_wr;
  logic [ADDR_W-1:0]  win_addr [NUM_BANKS];
  logic [PTR_W-1:0]   win_nxt  [NUM_BANKS];

  logic [NUM_REQ-1:0] ready, blocked;
  logic [31:0]        blk_pop [NUM_WARPS];
  logic [31:0]        acc_pop [NUM_WARPS];

  logic [NUM_BANKS-1:0] rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    addr_q   [NUM_BANKS];
  logic [ADDR_W-1:0]    addr_d   [NUM_BANKS];
  logic [NUM_REQ-1:0]   mask_q   [NUM_BANKS];
  logic [NUM_REQ-1:0]   mask_d   [NUM_BANKS];
  logic [PTR_W-1:0]     rr_ptr_q [NUM_BANKS];
  logic [PTR_W-1:0]     rr_ptr_d [NUM_BANKS];
  logic [BUSY_W-1:0]    busy_q   [NUM_BANKS];
  logic [BUSY_W-1:0]    busy_d   [NUM_BANKS];
  logic [AGE_W-1:0]     age_q    [NUM_REQ];
  logic [AGE_W-1:0]     age_d    [NUM_REQ];
  logic [NUM_WARPS-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]     conf_q [NUM_WARPS];
  logic [CNT_W-1:0]     conf_d [NUM_WARPS];
  logic [CNT_W-1:0]     gcnt_q [NUM_WARPS];
  logic [CNT_W-1:0]     gcnt_d [NUM_WARPS];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign r_bank[r] = req_bank[r*BK_W +: BK_W];
    assign r_addr[r] = req_addr[r*ADDR_W +: ADDR_W];
  end

  // A busy bank presents no requests to its picker, so its requesters see ready=0.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req[b]  = '0;
      bank_aged[b] = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        bank_req[b][r]  = req_valid[r] && (r_bank[r] == BK_W'(b)) && (busy_q[b] == '0);
        bank_aged[b][r] = bank_req[b][r] && (age_q[r] == AGE_MAX);
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    rr_age_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .req_mask_i  (bank_req[b]),
      .aged_mask_i (bank_aged[b]),
      .rr_ptr_i    (rr_ptr_q[b]),
      .grant_o     (bank_gnt[b])
    );
    assign bank_addr[b*ADDR_W +: ADDR_W]         = addr_q[b];
    assign bank_owner_mask[b*NUM_REQ +: NUM_REQ] = mask_q[b];
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      win_addr[b] = '0;
      win_wr[b]   = 1'b0;
      win_nxt[b]  = rr_ptr_q[b];
      bank_acc[b] = '0;
      bank_hit[b] = |bank_gnt[b];
      for (int r = 0; r < NUM_REQ; r++) begin
        if (bank_gnt[b][r]) begin
          win_addr[b] = r_addr[r];
          win_wr[b]   = req_is_write[r];
          win_nxt[b]  = PTR_W'((r + 1) % NUM_REQ);
        end
      end
      // Reads to the winner's word ride along with a read winner; writes always go alone.
      for (int r = 0; r < NUM_REQ; r++) begin
        bank_acc[b][r] = bank_gnt[b][r] ||
                         ((COALESCE_READS != 0) && bank_hit[b] && !win_wr[b] &&
                          bank_req[b][r] && !req_is_write[r] && (r_addr[r] == win_addr[b]));
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) ready = ready | bank_acc[b];
    if (reset) ready = '0;
  end

  assign req_ready = ready;
  assign blocked   = req_valid & ~ready;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_en_d[b]  = 1'b0;
      wr_en_d[b]  = 1'b0;
      addr_d[b]   = addr_q[b];
      mask_d[b]   = mask_q[b];
      rr_ptr_d[b] = rr_ptr_q[b];
      busy_d[b]   = (busy_q[b] != '0) ? busy_q[b] - BUSY_W'(1) : busy_q[b];
      if (bank_hit[b]) begin
        rd_en_d[b]  = !win_wr[b];
        wr_en_d[b]  = win_wr[b];
        addr_d[b]   = win_addr[b];
        mask_d[b]   = bank_acc[b];
        rr_ptr_d[b] = win_nxt[b];
        busy_d[b]   = BUSY_RELOAD;
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (blocked[r]) age_d[r] = (age_q[r] == AGE_MAX) ? AGE_MAX : age_q[r] + AGE_W'(1);
      else            age_d[r] = '0;
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      blk_pop[w] = '0;
      acc_pop[w] = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (warp_of(r, THREADS_PER_WARP) == w) begin
          blk_pop[w] = blk_pop[w] + 32'(blocked[r]);
          acc_pop[w] = acc_pop[w] + 32'(req_valid[r] & ready[r]);
        end
      end
      stall_d[w] = (blk_pop[w] != '0);
      if (stat_clear) begin
        conf_d[w] = '0;
        gcnt_d[w] = '0;
      end else begin
        conf_d[w] = CNT_W'(sat_add(32'(conf_q[w]), blk_pop[w], CNT_MAX));
        gcnt_d[w] = CNT_W'(sat_add(32'(gcnt_q[w]), acc_pop[w], CNT_MAX));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_q <= '0;
      wr_en_q <= '0;
      stall_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        addr_q[b]   <= '0;
        mask_q[b]   <= '0;
        rr_ptr_q[b] <= '0;
        busy_q[b]   <= '0;
      end
      for (int r = 0; r < NUM_REQ; r++) age_q[r] <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        conf_q[w] <= '0;
        gcnt_q[w] <= '0;
      end
    end else begin
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      stall_q <= stall_d;
      for (int b = 0; b < NUM_BANKS; b++) begin
        addr_q[b]   <= addr_d[b];
        mask_q[b]   <= mask_d[b];
        rr_ptr_q[b] <= rr_ptr_d[b];
        busy_q[b]   <= busy_d[b];
      end
      for (int r = 0; r < NUM_REQ; r++) age_q[r] <= age_d[r];
      for (int w = 0; w < NUM_WARPS; w++) begin
        conf_q[w] <= conf_d[w];
        gcnt_q[w] <= gcnt_d[w];
      end
    end
  end

  assign bank_rd_en = rd_en_q;
  assign bank_wr_en = wr_en_q;
  assign warp_stall = stall_q;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign warp_conflict_cnt[w*CNT_W +: CNT_W] = conf_q[w];
    assign warp_grant_cnt[w*CNT_W +: CNT_W]    = gcnt_q[w];
  end

endmodule

// File: tb/tb_bank_arbiter_mc.sv
// Directed bench: three arbiter instances (default, 3-cycle occupancy, age limit 2) share one stimulus.
module tb_bank_arbiter_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stat_clear = 1'b0;
  logic [7:0]  req_valid, req_is_write;
  logic [23:0] req_bank;
  logic [79:0] req_addr;

  logic [7:0]  rdy_a, rd_a, wr_a, rdy_b, rd_b, wr_b, rdy_c, rd_c, wr_c;
  logic [79:0] addr_a, addr_b, addr_c;
  logic [63:0] mask_a, mask_b, mask_c;
  logic [1:0]  stall_a, stall_b, stall_c;
  logic [15:0] ccnt_a, gcnt_a, ccnt_b, gcnt_b, ccnt_c, gcnt_c;

  int n_checks = 0;
  int n_errors = 0;
  int got_cyc;

  always #5 clk = ~clk;

  bank_arbiter_mc u_dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_bank(req_bank), .req_addr(req_addr),
    .req_is_write(req_is_write), .req_ready(rdy_a), .bank_rd_en(rd_a), .bank_wr_en(wr_a),
    .bank_addr(addr_a), .bank_owner_mask(mask_a), .warp_stall(stall_a), .stat_clear(stat_clear),
    .warp_conflict_cnt(ccnt_a), .warp_grant_cnt(gcnt_a));

  bank_arbiter_mc #(.BANK_BUSY_CYCLES(3)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_bank(req_bank), .req_addr(req_addr),
    .req_is_write(req_is_write), .req_ready(rdy_b), .bank_rd_en(rd_b), .bank_wr_en(wr_b),
    .bank_addr(addr_b), .bank_owner_mask(mask_b), .warp_stall(stall_b), .stat_clear(stat_clear),
    .warp_conflict_cnt(ccnt_b), .warp_grant_cnt(gcnt_b));

  bank_arbiter_mc #(.AGE_LIMIT(2)) u_dut_c (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_bank(req_bank), .req_addr(req_addr),
    .req_is_write(req_is_write), .req_ready(rdy_c), .bank_rd_en(rd_c), .bank_wr_en(wr_c),
    .bank_addr(addr_c), .bank_owner_mask(mask_c), .warp_stall(stall_c), .stat_clear(stat_clear),
    .warp_conflict_cnt(ccnt_c), .warp_grant_cnt(gcnt_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input int bank, input int addr, input bit wr);
    req_valid[r]          = 1'b1;
    req_bank[r*3 +: 3]    = 3'(bank);
    req_addr[r*10 +: 10]  = 10'(addr);
    req_is_write[r]       = wr;
  endtask

  task automatic clr_req();
    req_valid    = '0;
    req_is_write = '0;
    req_bank     = '0;
    req_addr     = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    clr_req();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr_req();
    // Reset state, with requests already pending
    set_req(0, 3, 1, 0);
    set_req(5, 3, 2, 0);
    step();
    step();
    chk("rst_ready", rdy_a, 8'h00);
    chk("rst_rd_en", rd_a, 8'h00);
    chk("rst_mask", mask_a, 64'h0);
    chk("rst_stall", stall_a, 2'b00);
    chk("rst_ccnt", ccnt_a, 16'h0);

    // r0 and r5 contend for bank 3: grants alternate
    reset = 1'b0;
    settle();
    chk("t1_ready_c1", rdy_a, 8'h01);
    step();
    chk("t1_rd_en_c1", rd_a, 8'h08);
    chk("t1_mask_c1", mask_a[31:24], 8'h01);
    chk("t1_addr_c1", addr_a[39:30], 10'd1);
    chk("t1_stall_c1", stall_a, 2'b10);
    settle();
    chk("t1_ready_c2", rdy_a, 8'h20);
    step();
    chk("t1_mask_c2", mask_a[31:24], 8'h20);
    chk("t1_addr_c2", addr_a[39:30], 10'd2);
    chk("t1_stall_c2", stall_a, 2'b01);
    settle();
    chk("t1_ready_c3", rdy_a, 8'h01);

    // Coalesced reads
    do_reset();
    set_req(1, 2, 'h15, 0);
    set_req(2, 2, 'h15, 0);
    set_req(6, 2, 'h15, 0);
    settle();
    chk("t2_ready", rdy_a, 8'h46);
    step();
    chk("t2_mask", mask_a[23:16], 8'h46);
    chk("t2_rd_en", rd_a, 8'h04);
    chk("t2_wr_en", wr_a, 8'h00);
    chk("t2_addr", addr_a[29:20], 10'h015);

    // Write in the middle of the reads is serialised
    do_reset();
    set_req(1, 2, 'h15, 0);
    set_req(2, 2, 'h15, 1);
    set_req(6, 2, 'h15, 0);
    settle();
    chk("t3_ready_rd", rdy_a, 8'h42);
    step();
    chk("t3_rd_en", rd_a, 8'h04);
    chk("t3_excl_1", rd_a & wr_a, 8'h00);
    chk("t3_mask_rd", mask_a[23:16], 8'h42);
    req_valid[1] = 1'b0;
    req_valid[6] = 1'b0;
    settle();
    chk("t3_ready_wr", rdy_a, 8'h04);
    step();
    chk("t3_wr_en", wr_a, 8'h04);
    chk("t3_excl_2", rd_a & wr_a, 8'h00);
    chk("t3_mask_wr", mask_a[23:16], 8'h04);

    // Three-cycle bank occupancy
    do_reset();
    set_req(0, 0, 5, 1);
    set_req(1, 0, 6, 1);
    settle();
    chk("t4_ready_r0", rdy_b, 8'h01);
    step();
    chk("t4_wr_r0", wr_b, 8'h01);
    chk("t4_addr_r0", addr_b[9:0], 10'd5);
    req_valid[0] = 1'b0;
    settle();
    chk("t4_busy_a", rdy_b, 8'h00);
    step();
    chk("t4_strobe_off", wr_b, 8'h00);
    settle();
    chk("t4_busy_b", rdy_b, 8'h00);
    step();
    settle();
    chk("t4_ready_r1", rdy_b, 8'h02);
    step();
    chk("t4_wr_r1", wr_b, 8'h01);
    chk("t4_addr_r1", addr_b[9:0], 10'd6);
    chk("t4_mask_r1", mask_b[7:0], 8'h02);

    // Aged r7 against r0..r6 held valid on bank 0
    do_reset();
    for (int r = 0; r < 8; r++) set_req(r, 0, r, 0);
    got_cyc = 0;
    for (int k = 1; k <= 12 && got_cyc == 0; k++) begin
      settle();
      if (rdy_c[7]) begin
        got_cyc = k;
        req_valid[7] = 1'b0;
      end
      step();
    end
    chk("t5_r7_cycle", got_cyc, 8);
    chk("t5_r7_bound", (got_cyc > 0) && (got_cyc <= 10), 1'b1);

    // Statistics saturation and clear
    do_reset();
    set_req(0, 0, 1, 0);
    set_req(1, 0, 2, 0);
    repeat (10) step();
    chk("t6_ccnt_10", ccnt_a[7:0], 8'd10);
    repeat (290) step();
    chk("t6_ccnt_sat", ccnt_a[7:0], 8'd255);
    chk("t6_gcnt_sat", gcnt_a[7:0], 8'd255);
    chk("t6_ccnt_w1", ccnt_a[15:8], 8'd0);
    chk("t6_gcnt_w1", gcnt_a[15:8], 8'd0);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    chk("t6_ccnt_clr", ccnt_a[7:0], 8'd0);
    chk("t6_gcnt_clr", gcnt_a[7:0], 8'd0);
    step();
    chk("t6_ccnt_resume", ccnt_a[7:0], 8'd1);

    // Reset while a bank is occupied
    do_reset();
    set_req(0, 0, 7, 1);
    step();
    chk("t7_wr_pre", wr_b, 8'h01);
    clr_req();
    reset = 1'b1;
    step();
    chk("t7_wr_rst", wr_b, 8'h00);
    chk("t7_rd_rst", rd_b, 8'h00);
    chk("t7_addr_rst", addr_b, 80'h0);
    chk("t7_mask_rst", mask_b, 64'h0);
    chk("t7_stall_rst", stall_b, 2'b00);
    chk("t7_cnt_rst", {ccnt_b, gcnt_b}, 32'h0);
    reset = 1'b0;
    set_req(1, 0, 8, 1);
    settle();
    chk("t7_ready_post", rdy_b, 8'h02);
    step();
    chk("t7_wr_post", wr_b, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
